// File: rtl/demod_segment_slicer.sv
// Receive-side bit slicer: correlates SEG_PER_SYM segments against the bit-0 and bit-1
// reference tables by accumulated absolute distance and emits one hard bit plus a soft margin.
module demod_segment_slicer #(
  parameter int WIDTH       = 32,
  parameter int SEG_PER_SYM = 4,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       segment_in,
  input  logic                   segment_valid,
  input  logic [WIDTH-1:0]       array_ref_wire,
  input  logic [WIDTH-1:0]       array_ref_m_wire,
  output logic [IDX_W-1:0]       seg_index,
  output logic [WIDTH-1:0]       output_bit,
  output logic [WIDTH+IDX_W-1:0] dist_margin,
  output logic                   valid,
  output logic                   busy
);

  localparam int ACC_W = WIDTH + IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [ACC_W-1:0] acc0;
  logic [ACC_W-1:0] acc1;
  logic [WIDTH-1:0] dist0;
  logic [WIDTH-1:0] dist1;
  logic [ACC_W-1:0] margin;
  logic             last_seg;

  // Unsigned absolute distances formed as larger-minus-smaller.
  assign dist0    = (segment_in >= array_ref_wire)   ? (segment_in - array_ref_wire)
                                                     : (array_ref_wire - segment_in);
  assign dist1    = (segment_in >= array_ref_m_wire) ? (segment_in - array_ref_m_wire)
                                                     : (array_ref_m_wire - segment_in);
  assign margin   = (acc0 >= acc1) ? (acc0 - acc1) : (acc1 - acc0);
  assign last_seg = (seg_index == IDX_W'(SEG_PER_SYM - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (segment_valid && last_seg) next_state = DECIDE;
      DECIDE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // seg_index holds at SEG_PER_SYM-1 on the final beat and only returns to zero in DECIDE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_index   <= '0;
      acc0        <= '0;
      acc1        <= '0;
      output_bit  <= '0;
      dist_margin <= '0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc0      <= '0;
            acc1      <= '0;
            seg_index <= '0;
          end
        end
        ACCUM: begin
          if (segment_valid) begin
            acc0 <= acc0 + ACC_W'(dist0);
            acc1 <= acc1 + ACC_W'(dist1);
            if (!last_seg) begin
              seg_index <= seg_index + IDX_W'(1);
            end
          end
        end
        DECIDE: begin
          output_bit  <= {{(WIDTH-1){1'b0}}, (acc1 < acc0)};
          dist_margin <= margin;
          valid       <= 1'b1;
          seg_index   <= '0;
        end
        default: begin
          seg_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demod_segment_slicer.sv
// Directed self-checking bench for demod_segment_slicer with hand-computed expectations.
module tb_demod_segment_slicer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] segment_in;
  logic        segment_valid;
  logic [31:0] array_ref_wire;
  logic [31:0] array_ref_m_wire;
  logic [1:0]  seg_index;
  logic [31:0] output_bit;
  logic [33:0] dist_margin;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  demod_segment_slicer #(.WIDTH(32), .SEG_PER_SYM(4), .IDX_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .segment_in       (segment_in),
    .segment_valid    (segment_valid),
    .array_ref_wire   (array_ref_wire),
    .array_ref_m_wire (array_ref_m_wire),
    .seg_index        (seg_index),
    .output_bit       (output_bit),
    .dist_margin      (dist_margin),
    .valid            (valid),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs set before a step are sampled at its rising edge; outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start, then feed four segments back-to-back.
  task automatic run_bit(input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
    start = 1'b1;
    segment_valid = 1'b0;
    step();
    start = 1'b0;
    segment_valid = 1'b1;
    segment_in = s0; step();
    segment_in = s1; step();
    segment_in = s2; step();
    segment_in = s3; step();
    segment_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    segment_in = '0;
    segment_valid = 1'b0;
    array_ref_wire = 32'h10;
    array_ref_m_wire = 32'h90;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_idx", 64'(seg_index), 64'd0);
    check("rst_bit", 64'(output_bit), 64'd0);
    check("rst_margin", 64'(dist_margin), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Test 1: async reset after two accepted segments
    start = 1'b1; step();
    start = 1'b0;
    segment_valid = 1'b1; segment_in = 32'h20;
    step(); step();
    check("t1_idx_before", 64'(seg_index), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("t1_busy_async", 64'(busy), 64'd0);
    check("t1_valid_async", 64'(valid), 64'd0);
    check("t1_idx_async", 64'(seg_index), 64'd0);
    segment_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("t1_no_valid", 64'(valid), 64'd0);
    // acc0=4*0x10=0x40, acc1=4*0x70=0x1C0 -> bit 0, margin 0x180
    run_bit(32'h20, 32'h20, 32'h20, 32'h20);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_bit", 64'(output_bit), 64'd0);
    check("t1_margin", 64'(dist_margin), 64'h180);
    step();

    // Test 2: segment_valid high in the start cycle is discarded; valid 5 cycles after start
    segment_in = 32'h90;
    segment_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_idx0", 64'(seg_index), 64'd0);
    step();
    check("t2_idx1", 64'(seg_index), 64'd1);
    step(); step();
    check("t2_idx3", 64'(seg_index), 64'd3);
    step();
    segment_valid = 1'b0;
    check("t2_idx_hold", 64'(seg_index), 64'd3);
    check("t2_valid_early", 64'(valid), 64'd0);
    check("t2_busy_decide", 64'(busy), 64'd1);
    step();
    check("t2_valid", 64'(valid), 64'd1);
    check("t2_busy_drop", 64'(busy), 64'd0);
    check("t2_bit", 64'(output_bit), 64'd1);
    check("t2_margin", 64'(dist_margin), 64'h200);
    check("t2_idx_wrap", 64'(seg_index), 64'd0);
    step();
    check("t2_valid_pulse", 64'(valid), 64'd0);
    check("t2_bit_hold", 64'(output_bit), 64'd1);
    check("t2_margin_hold", 64'(dist_margin), 64'h200);

    // Test 3: acc0=4, acc1=0x200 -> bit 0, margin 0x1FC
    run_bit(32'h10, 32'h12, 32'h0E, 32'h10);
    check("t3_valid", 64'(valid), 64'd1);
    check("t3_bit", 64'(output_bit), 64'd0);
    check("t3_margin", 64'(dist_margin), 64'h1FC);
    step();

    // Test 4: equidistant segments tie to bit 0
    run_bit(32'h50, 32'h50, 32'h50, 32'h50);
    check("t4_valid", 64'(valid), 64'd1);
    check("t4_bit", 64'(output_bit), 64'd0);
    check("t4_margin", 64'(dist_margin), 64'h0);
    step();

    // Test 5: 1-of-3 gapped beats of 0x80 (acc0=0x1C0, acc1=0x40), mid-ACCUM start ignored
    start = 1'b1; step();
    start = 1'b0;
    segment_in = 32'h80;
    for (int k = 0; k < 4; k++) begin
      segment_valid = 1'b1;
      step();
      segment_valid = 1'b0;
      if (k < 3) begin
        if (k == 1) start = 1'b1;
        step();
        start = 1'b0;
        step();
        check($sformatf("t5_idx_%0d", k), 64'(seg_index), 64'(k + 1));
        check($sformatf("t5_busy_%0d", k), 64'(busy), 64'd1);
      end
    end
    check("t5_valid_early", 64'(valid), 64'd0);
    step();
    check("t5_valid", 64'(valid), 64'd1);
    check("t5_bit", 64'(output_bit), 64'd1);
    check("t5_margin", 64'(dist_margin), 64'h180);
    step();
    check("t5_idle", 64'(busy), 64'd0);

    // Test 6: extreme values, acc0=0x3_FFFFFFFC without overflow
    array_ref_wire = 32'h0;
    array_ref_m_wire = 32'hFFFF_FFFF;
    run_bit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t6_valid", 64'(valid), 64'd1);
    check("t6_bit", 64'(output_bit), 64'd1);
    check("t6_margin", 64'(dist_margin), 64'h3_FFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
